// File: rtl/sipo_block_assembler_if.sv
// Byte-in / block-out bus of the SIPO block assembler.
// The slave modport is the assembler side; the master modport is the feeder/consumer side.
interface sipo_block_assembler_if #(
   parameter int unsigned BYTES = 16
);
   localparam int unsigned Width      = 8 * BYTES;
   localparam int unsigned CountWidth = $clog2(BYTES) + 1;

   logic [7:0]            byte_in;
   logic                  byte_valid;
   logic [Width-1:0]      block_out;
   logic                  block_valid;
   logic                  block_ready;
   logic [CountWidth-1:0] byte_count;
   logic                  overflow;
   logic                  clear_overflow;
   logic                  timeout;

   modport master (
      output byte_in, byte_valid, block_ready, clear_overflow,
      input  block_out, block_valid, byte_count, overflow, timeout
   );

   modport slave (
      input  byte_in, byte_valid, block_ready, clear_overflow,
      output block_out, block_valid, byte_count, overflow, timeout
   );
endinterface

// File: rtl/sipo_block_assembler.sv
// Collects a byte stream into one 8*BYTES-bit block, first byte in the MSBs, and holds the
// finished block under a valid/ready handshake. Bytes arriving while a block is pending are
// dropped and flagged in a sticky overflow bit.
// Optional: define SIPO_ASM_TIMEOUT_EN to discard a partial block after TIMEOUT_CYCLES idle
// cycles (timeout pulses for one cycle). Without it, timeout is tied low.
// BYTES must be at least 2.
module sipo_block_assembler #(
   parameter int unsigned BYTES          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input logic                   clk,
   input logic                   reset,
   sipo_block_assembler_if.slave bus
);
   localparam int unsigned Width      = 8 * BYTES;
   localparam int unsigned CountWidth = $clog2(BYTES) + 1;

   typedef enum logic [0:0] {StCollect, StFull} state_e;

   state_e                state_q, state_d;
   logic [Width-1:0]      shift_q, shift_d;
   logic [Width-1:0]      block_q, block_d;
   logic                  valid_q, valid_d;
   logic [CountWidth-1:0] count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  timeout_q, timeout_d;

   logic                  accept;
   logic [CountWidth-1:0] base_count;
   logic [Width-1:0]      shifted;
   logic                  expire;

   assign shifted = {shift_q[Width-9:0], bus.byte_in};

`ifdef SIPO_ASM_TIMEOUT_EN
   localparam int unsigned IdleWidth = $clog2(TIMEOUT_CYCLES) + 1;

   logic [IdleWidth-1:0] idle_q, idle_d;

   // Idle counter: runs only while a partial block waits with no byte arriving.
   always_comb begin
      idle_d = '0;
      expire = 1'b0;
      if (state_q == StCollect && !bus.byte_valid && count_q != '0) begin
         if (idle_q == IdleWidth'(TIMEOUT_CYCLES - 1)) begin
            expire = 1'b1;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end
   end

   // Idle counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign expire             = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   // Next-state logic: byte acceptance, block completion, handshake and overflow.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      block_d    = block_q;
      valid_d    = valid_q;
      count_d    = count_q;
      ovf_d      = ovf_q & ~bus.clear_overflow;
      timeout_d  = 1'b0;
      accept     = 1'b0;
      base_count = count_q;

      unique case (state_q)
         StCollect: accept = bus.byte_valid;
         StFull: begin
            if (bus.block_ready) begin
               // Handshake; a byte in the same cycle starts the next block.
               valid_d    = 1'b0;
               count_d    = '0;
               state_d    = StCollect;
               base_count = '0;
               accept     = bus.byte_valid;
            end else if (bus.byte_valid) begin
               // A new drop wins over a simultaneous clear.
               ovf_d = 1'b1;
            end
         end
         default: state_d = StCollect;
      endcase

      if (accept) begin
         shift_d = shifted;
         if (base_count == CountWidth'(BYTES - 1)) begin
            block_d = shifted;
            valid_d = 1'b1;
            count_d = CountWidth'(BYTES);
            state_d = StFull;
         end else begin
            count_d = base_count + 1'b1;
         end
      end

      if (expire) begin
         shift_d   = '0;
         count_d   = '0;
         timeout_d = 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StCollect;
         shift_q   <= '0;
         block_q   <= '0;
         valid_q   <= 1'b0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         block_q   <= block_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.block_out   = block_q;
   assign bus.block_valid = valid_q;
   assign bus.byte_count  = count_q;
   assign bus.overflow    = ovf_q;
   assign bus.timeout     = timeout_q;
endmodule
